// File: rtl/my_multiplier_if.sv
// rtl/my_multiplier_if.sv - request/result bundle of the iterative 16x16 multiplier
interface my_multiplier_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        overflow;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product,
        input  overflow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product,
        output overflow
    );
endinterface

// File: rtl/my_multiplier.sv
// rtl/my_multiplier.sv - shift-and-add unsigned multiplier, fixed 16 iterations
module my_multiplier (
    input  logic              clk,
    input  logic              reset,
    my_multiplier_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        overflow_q, overflow_d;
    logic        busy_o, done_o;

    logic        load;
    logic        iter_last;
    logic [31:0] acc_sum;

    // A new operation is accepted only from IDLE or straight out of DONE
    assign load      = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign iter_last = (cnt_q == 5'd15);
    // Carry past bit 31 cannot occur for 16x16 operands, so a 32-bit sum is exact
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'h0000_0000);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN always lasts 16 edges, no early exit on zero operands
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = iter_last ? ST_DONE : ST_RUN;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_RUN:  busy_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand latch, one add/shift step per RUN edge, result capture
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        if (load) begin
            mcand_d  = {16'h0000, bus.a};
            mplier_d = bus.b;
            acc_d    = 32'h0000_0000;
            cnt_d    = 5'd0;
        end else if (state_q == ST_RUN) begin
            acc_d    = acc_sum;
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[15:1]};
            cnt_d    = cnt_q + 5'd1;
            if (iter_last) begin
                product_d  = acc_sum[15:0];
                overflow_d = |acc_sum[31:16];
            end
        end
    end

    // Datapath registers; result registers hold until the next entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q    <= 32'h0000_0000;
            mplier_q   <= 16'h0000;
            acc_q      <= 32'h0000_0000;
            cnt_q      <= 5'd0;
            product_q  <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_o;
    assign bus.done     = done_o;
    assign bus.product  = product_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_my_multiplier.sv
// tb/tb_my_multiplier.sv - directed-vector bench for my_multiplier
module tb_my_multiplier;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    my_multiplier_if bus ();

    my_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_p = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the first busy cycle is being sampled; walks to the done cycle
    task automatic wait_result(input string tag, input logic [15:0] ep, input logic eo,
                               input bit inject, input bit keep_ops);
        int n;
        n = 0;
        chk({tag, " busy_first"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " product_held"}, {16'd0, bus.product}, {16'd0, last_p});
        while (bus.busy && n < 40) begin
            if (n == 8) chk({tag, " done_in_run"}, {31'd0, bus.done}, 32'd0);
            if (!keep_ops) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
            if (inject && n == 4) begin
                bus.start = 1'b1;
                bus.a     = 16'd7;
                bus.b     = 16'd9;
            end
            if (inject && n == 5) bus.start = 1'b0;
            n++;
            tick();
        end
        chk({tag, " busy_cycles"}, n, 32'd16);
        chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " product"}, {16'd0, bus.product}, {16'd0, ep});
        chk({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
        last_p = ep;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ep, input logic eo, input bit inject);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_result(tag, ep, eo, inject, 1'b0);
        tick();
        chk({tag, " done_after"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " product_after"}, {16'd0, bus.product}, {16'd0, ep});
    endtask

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst product", {16'd0, bus.product}, 32'd0);
        chk("rst overflow", {31'd0, bus.overflow}, 32'd0);
        tick();
        chk("idle stays", {31'd0, bus.busy}, 32'd0);

        run_op("3x5",        16'd3,     16'd5,     16'h000F, 1'b0, 1'b0);
        run_op("ffffx2",     16'hFFFF,  16'd2,     16'hFFFE, 1'b1, 1'b0);
        run_op("100x100",    16'h0100,  16'h0100,  16'h0000, 1'b1, 1'b0);
        run_op("ffx101",     16'h00FF,  16'h0101,  16'hFFFF, 1'b0, 1'b0);
        run_op("0xabcd",     16'h0000,  16'hABCD,  16'h0000, 1'b0, 1'b0);
        run_op("1234x1",     16'h1234,  16'h0001,  16'h1234, 1'b0, 1'b0);
        run_op("2x4 inject", 16'd2,     16'd4,     16'h0008, 1'b0, 1'b1);

        // start held through done: second op begins with no idle cycle
        bus.a     = 16'd3;
        bus.b     = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.a = 16'd4;
        bus.b = 16'd6;
        wait_result("b2b first", 16'h000F, 1'b0, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        chk("b2b no idle", {31'd0, bus.busy}, 32'd1);
        chk("b2b done low", {31'd0, bus.done}, 32'd0);
        last_p = 16'h000F;
        wait_result("b2b second", 16'h0018, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b done_after", {31'd0, bus.done}, 32'd0);

        // reset wins over start on the same edge
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'd5;
        bus.b     = 16'd5;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst+start busy", {31'd0, bus.busy}, 32'd0);
        chk("rst+start product", {16'd0, bus.product}, 32'd0);
        last_p = 16'h0000;

        // abort: make product nonzero first, then reset on 8th busy cycle
        run_op("pre abort", 16'h1234, 16'h0001, 16'h1234, 1'b0, 1'b0);
        bus.a     = 16'd100;
        bus.b     = 16'd200;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("abort busy8", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort product", {16'd0, bus.product}, 32'd0);
        chk("abort overflow", {31'd0, bus.overflow}, 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("abort no done", dones, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/my_multiplier.md
MY_MULTIPLIER -- requirements
Module: my_multiplier

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 The block SHALL expose port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-003 The block SHALL expose port reset, input, 1 bit: synchronous active-high reset, sampled on rising clk.
REQ-004 The block SHALL expose port start, input, 1 bit: request a multiply of a and b.
REQ-005 The block SHALL expose port a, input, 16 bits: multiplicand, unsigned.
REQ-006 The block SHALL expose port b, input, 16 bits: multiplier, unsigned.
REQ-007 The block SHALL expose port busy, output, 1 bit: high while iterating.
REQ-008 The block SHALL expose port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The block SHALL expose port product, output, 16 bits: low 16 bits of a*b.
REQ-010 The block SHALL expose port overflow, output, 1 bit: high when the true 32-bit product exceeds 16'hFFFF.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1 at an edge (E0), the block SHALL latch a into a 32-bit shift register (upper half 0), latch b into a 16-bit shift register, clear a 32-bit accumulator, clear a 5-bit iteration counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-014 Each RUN edge SHALL do the following: if the multiplier LSB is 1, add the multiplicand to the accumulator mod 2^32; then shift the multiplicand left 1; shift the multiplier right 1 with zero fill; and increment the counter.
REQ-015 RUN SHALL last exactly 16 edges (E1..E16) with no early termination regardless of operand values.
REQ-016 At E16, the block SHALL enter DONE, load product with acc[15:0], and load overflow with the OR of acc[31:16].
REQ-017 busy SHALL be 1 exactly while the state is RUN, which is 16 cycles.
REQ-018 done SHALL be 1 exactly while the state is DONE, which is 1 cycle, immediately after the last busy cycle.
REQ-019 From DONE, the block SHALL go to RUN if start=1 (accepting a new operation exactly as in REQ-012), else go to IDLE.
REQ-020 The block SHALL ignore start, a and b during RUN; latched operands alone SHALL determine the result.
REQ-021 product and overflow SHALL be registered and SHALL change only at entry to DONE or on reset, holding their value through IDLE and the following RUN.
REQ-022 The block SHALL not retain accumulator carry beyond bit 31; the 32-bit result is always exact because 16x16 fits in 32 bits.
REQ-023 If reset=1 and start=1 occur on the same edge, reset SHALL take priority.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL enter IDLE, set busy=0, done=0, product=16'h0000 and overflow=0, and clear all internal registers.
REQ-025 A reset asserted during RUN or DONE SHALL abort the operation: no done pulse SHALL follow and product SHALL read 0 on the next cycle.
REQ-026 The block SHALL require a reset after power-up; outputs are undefined before the first reset edge.

Verification
REQ-027 Reset test: apply reset for 2 cycles -> busy=0, done=0, product=16'h0000, overflow=0.
REQ-028 Basic multiply: a=3, b=5, start pulse -> busy high for 16 cycles, then done=1 for 1 cycle with product=16'h000F and overflow=0; product stays 16'h000F afterwards.
REQ-029 Overflow cases: a=16'hFFFF, b=2 -> product=16'hFFFE, overflow=1; a=16'h0100, b=16'h0100 -> product=16'h0000, overflow=1; a=16'h00FF, b=16'h0101 -> product=16'hFFFF, overflow=0.
REQ-030 Zero and identity: a=0, b=16'hABCD -> product=0, overflow=0; a=16'h1234, b=1 -> product=16'h1234, overflow=0; both cases SHALL still take 16 busy cycles.
REQ-031 Handshake:
- A start pulse with a=7, b=9 issued mid-RUN of 2x4 SHALL be ignored, so product=8.
- start held high through the done cycle SHALL begin the next run immediately, giving busy high the cycle after done with no IDLE cycle between.
- Operands a, b changed during RUN SHALL not affect the result.
REQ-032 Abort: start a=100, b=200; assert reset at the 8th busy cycle -> next cycle busy=0, done never pulses, and product=0.
